// File: rtl/gowin_dpb_pkg.sv
// gowin_dpb shared types and geometry.
// 2048 x 8 true dual-port block RAM.
package gowin_dpb_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/gowin_dpb_port.sv
// gowin_dpb per-port read latch and output register.
// Output register present when GOWIN_DPB_OUTREG_EN is defined.
module gowin_dpb_port
  import gowin_dpb_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          oce,
  input  logic          wre,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] lat;

  // writes leave the read path untouched
  always_ff @(posedge clk) begin
    if (reset)
      lat <= '0;
    else if (ce && !wre)
      lat <= rdata;
  end

`ifdef GOWIN_DPB_OUTREG_EN
  logic [DW-1:0] oreg;

  always_ff @(posedge clk) begin
    if (reset)
      oreg <= '0;
    else if (ce && oce)
      oreg <= lat;
  end

  assign dout = oreg;
`else
  logic unused_oce;

  assign unused_oce = oce;
  assign dout       = lat;
`endif

endmodule

// File: rtl/gowin_dpb.sv
// gowin_dpb: true dual-port RAM, one clock.
// Define GOWIN_DPB_OUTREG_EN for the 2-edge output register.
module gowin_dpb
  import gowin_dpb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          reseta,
  input  logic          resetb,
  input  logic          cea,
  input  logic          ceb,
  input  logic          ocea,
  input  logic          oceb,
  input  logic          wrea,
  input  logic          wreb,
  input  logic [AW-1:0] ada,
  input  logic [AW-1:0] adb,
  input  logic [DW-1:0] dina,
  input  logic [DW-1:0] dinb,
  output logic [DW-1:0] douta,
  output logic [DW-1:0] doutb
);

  localparam int DEP = 2 ** AW;

  logic [DW-1:0] mem [DEP];
  logic [DW-1:0] rda;
  logic [DW-1:0] rdb;

  // port A is applied last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (ceb && wreb)
      mem[adb] <= dinb;
    if (cea && wrea)
      mem[ada] <= dina;
  end

  assign rda = mem[ada];
  assign rdb = mem[adb];

  gowin_dpb_port #(.DW(DW)) u_pa (
    .clk   (clk),
    .reset (reseta),
    .ce    (cea),
    .oce   (ocea),
    .wre   (wrea),
    .rdata (rda),
    .dout  (douta)
  );

  gowin_dpb_port #(.DW(DW)) u_pb (
    .clk   (clk),
    .reset (resetb),
    .ce    (ceb),
    .oce   (oceb),
    .wre   (wreb),
    .rdata (rdb),
    .dout  (doutb)
  );

endmodule

// File: tb/tb_gowin_dpb.sv
// Scoreboard bench for gowin_dpb.
// Follows GOWIN_DPB_OUTREG_EN for the expected read latency.
module tb_gowin_dpb;

`ifdef GOWIN_DPB_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reseta, resetb;
  logic        cea, ceb, ocea, oceb;
  logic        wrea, wreb;
  logic [10:0] ada, adb;
  logic [7:0]  dina, dinb;
  logic [7:0]  douta, doutb;

  gowin_dpb dut (
    .clk    (clk),
    .reseta (reseta),
    .resetb (resetb),
    .cea    (cea),
    .ceb    (ceb),
    .ocea   (ocea),
    .oceb   (oceb),
    .wrea   (wrea),
    .wreb   (wreb),
    .ada    (ada),
    .adb    (adb),
    .dina   (dina),
    .dinb   (dinb),
    .douta  (douta),
    .doutb  (doutb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic        oce;
    logic        rst;
    logic [10:0] ad;
    logic [7:0]  din;
  } pin_t;

  typedef struct {
    int         cyc;
    logic [7:0] ea;
    logic [7:0] eb;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  // reference: array, per-port last read word and pipeline word
  logic [7:0] mem_m [2048];
  logic [7:0] la = 0, lb = 0, oa = 0, ob = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total += 2;
      if (douta !== e.ea) begin
        bad++;
        $display("FAIL douta cyc=%0d got=%h exp=%h",
                 e.cyc, douta, e.ea);
      end
      if (doutb !== e.eb) begin
        bad++;
        $display("FAIL doutb cyc=%0d got=%h exp=%h",
                 e.cyc, doutb, e.eb);
      end
    end
  end

  function automatic pin_t mk(logic c, logic w, logic o,
                              logic r, logic [10:0] a,
                              logic [7:0] d);
    pin_t p;
    p.ce = c; p.we = w; p.oce = o;
    p.rst = r; p.ad = a; p.din = d;
    return p;
  endfunction

  function automatic pin_t idle();
    return mk(0, 0, 1, 0, 11'd0, 8'd0);
  endfunction

  task automatic go(input pin_t a, input pin_t b);
    logic [7:0] ra, rb;
    exp_t e;
    cea = a.ce; wrea = a.we; ocea = a.oce;
    reseta = a.rst; ada = a.ad; dina = a.din;
    ceb = b.ce; wreb = b.we; oceb = b.oce;
    resetb = b.rst; adb = b.ad; dinb = b.din;
    ra = mem_m[a.ad];
    rb = mem_m[b.ad];
    if (a.rst) begin
      la = 0; oa = 0;
    end else begin
      if (a.ce && a.oce) oa = la;
      if (a.ce && !a.we) la = ra;
    end
    if (b.rst) begin
      lb = 0; ob = 0;
    end else begin
      if (b.ce && b.oce) ob = lb;
      if (b.ce && !b.we) lb = rb;
    end
    if (b.ce && b.we) mem_m[b.ad] = b.din;
    if (a.ce && a.we) mem_m[a.ad] = a.din;
    e.cyc = cyc + 1;
    e.ea = OUTREG ? oa : la;
    e.eb = OUTREG ? ob : lb;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [10:0] a,
                      input logic [7:0] d);
    go(mk(1, 1, 1, 0, a, d), idle());
  endtask

  task automatic rd_a(input logic [10:0] a,
                      output logic [7:0] d);
    go(mk(1, 0, 1, 0, a, 0), idle());
    if (OUTREG) go(mk(1, 0, 1, 0, a, 0), idle());
    d = douta;
  endtask

  initial begin
    logic [7:0]  hi, lo, d;
    logic [15:0] ptr;
    int          n;
    for (int i = 0; i < 2048; i++) mem_m[i] = 0;
    cea = 0; ceb = 0; ocea = 1; oceb = 1;
    wrea = 0; wreb = 0; ada = 0; adb = 0;
    dina = 0; dinb = 0; reseta = 1; resetb = 1;
    @(posedge clk);
    #1;
    go(mk(0, 0, 0, 1, 0, 0), mk(0, 0, 0, 1, 0, 0));
    go(idle(), idle());
    // explicit clear so the bench never depends on power-up contents
    for (int i = 0; i < 1024; i++)
      go(mk(1, 1, 1, 0, 11'(2*i), 0),
         mk(1, 1, 1, 0, 11'(2*i+1), 0));

    wr_a(11'd4, 8'h5A);
    go(mk(1, 0, 1, 0, 11'd4, 0), idle());
    go(mk(1, 0, 1, 0, 11'd4, 0), idle());
    go(idle(), idle());

    for (int i = 0; i < 10; i++) begin
      logic [15:0] base, nxt;
      base = 16'(4 + 64 * i);
      nxt  = (i == 9) ? 16'd0 : base + 16'd64;
      go(mk(1, 1, 1, 0, base[10:0], 8'(i)),
         mk(1, 1, 1, 0, base[10:0] + 11'd2, nxt[15:8]));
      go(mk(1, 1, 1, 0, base[10:0] + 11'd1, 8'(i)),
         mk(1, 1, 1, 0, base[10:0] + 11'd3, nxt[7:0]));
    end
    ptr = 16'd4;
    n = 0;
    while (ptr != 0 && n < 20) begin
      rd_a(ptr[10:0], d);
      rd_a(ptr[10:0] + 11'd2, hi);
      rd_a(ptr[10:0] + 11'd3, lo);
      ptr = {hi, lo};
      n++;
    end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL list_walk got=%0d exp=10", n);
    end

    go(mk(1, 1, 1, 0, 11'd100, 8'h11),
       mk(1, 0, 1, 0, 11'd100, 0));
    go(idle(), mk(1, 0, 1, 0, 11'd100, 0));
    go(idle(), mk(1, 0, 1, 0, 11'd100, 0));
    go(idle(), idle());

    go(mk(1, 1, 1, 0, 11'd200, 8'hAA),
       mk(1, 1, 1, 0, 11'd200, 8'h55));
    go(idle(), mk(1, 0, 1, 0, 11'd200, 0));
    go(idle(), mk(1, 0, 1, 0, 11'd200, 0));

    go(mk(1, 0, 1, 0, 11'd4, 0), idle());
    go(mk(1, 0, 1, 0, 11'd68, 0), idle());
    go(mk(1, 0, 1, 1, 11'd132, 0), idle());
    go(mk(1, 0, 1, 0, 11'd4, 0), idle());
    go(mk(1, 0, 1, 0, 11'd68, 0), idle());
    go(mk(1, 0, 1, 0, 11'd68, 0), idle());

    go(mk(1, 0, 0, 0, 11'd200, 0), idle());
    go(mk(1, 0, 0, 0, 11'd100, 0), idle());
    go(mk(1, 0, 0, 0, 11'd4, 0), idle());
    go(mk(1, 0, 1, 0, 11'd4, 0), idle());

    go(mk(0, 1, 1, 0, 11'd4, 8'hEE), idle());
    go(mk(1, 0, 1, 0, 11'd4, 0), idle());
    go(mk(1, 0, 1, 0, 11'd4, 0), idle());

    for (int k = 0; k < 600; k++) begin
      pin_t pa, pb;
      pa.ce  = ($urandom % 4) != 0;
      pa.we  = $urandom % 2;
      pa.oce = ($urandom % 4) != 0;
      pa.rst = ($urandom % 20) == 0;
      pa.ad  = ($urandom % 8 == 0) ? 11'($urandom)
                                   : 11'($urandom % 24);
      pa.din = 8'($urandom);
      pb.ce  = ($urandom % 4) != 0;
      pb.we  = $urandom % 2;
      pb.oce = ($urandom % 4) != 0;
      pb.rst = ($urandom % 20) == 0;
      pb.ad  = ($urandom % 8 == 0) ? 11'($urandom)
                                   : 11'($urandom % 24);
      pb.din = 8'($urandom);
      go(pa, pb);
    end
    go(idle(), idle());

    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
